// File: rtl/div_pkg.sv
// Shared defaults and types for the division scheduler.
package div_pkg;

    localparam int D_W_DEF      = 16;
    localparam int FRAC_BIT_DEF = 13;
    localparam int N_REQ_DEF    = 4;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEF = idw(N_REQ_DEF);

    // Default-width operand stage record; the top mirrors this shape at its own widths.
    typedef struct packed {
        logic                      valid;
        logic [IDW_DEF-1:0]        id;
        logic signed [D_W_DEF-1:0] dividend;
        logic signed [D_W_DEF-1:0] divisor;
    } stage_t;

endpackage

// File: rtl/div_fast.sv
// Combinational signed fixed-point divider: magnitude divide, sign restored afterwards.
module div_fast #(
    parameter int D_W      = 16,
    parameter int FRAC_BIT = 13
) (
    input  logic signed [D_W-1:0] dividend,
    input  logic signed [D_W-1:0] divisor,
    output logic signed [D_W-1:0] quotient
);

    logic                      neg;
    logic [D_W-1:0]            a_mag;
    logic [D_W-1:0]            b_mag;
    logic [D_W+FRAC_BIT-1:0]   num;
    logic [D_W+FRAC_BIT-1:0]   den;
    logic [D_W-1:0]            q_mag;

    always_comb begin
        neg   = dividend[D_W-1] ^ divisor[D_W-1];
        a_mag = dividend[D_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
        b_mag = divisor[D_W-1]  ? $unsigned(-divisor)  : $unsigned(divisor);
        num   = {a_mag, {FRAC_BIT{1'b0}}};
        den   = {{FRAC_BIT{1'b0}}, b_mag};
        // A zero divisor yields zero rather than an undefined value.
        q_mag = (b_mag == '0) ? '0 : D_W'(num / den);
        quotient = neg ? $signed(-q_mag) : $signed(q_mag);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the entry after the last winner.
module rr_arbiter
    import div_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = idw(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand_idx;
    logic           found;
    int             cand;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

    // Pointer moves only on a real transfer so a stalled winner keeps priority.
    always_comb begin
        ptr_d = advance ? idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IDW'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shared two-stage fixed-point divider with round-robin requesters.
// Optional divide-by-zero handling and O_DIV0 port: DIV_SCHED_DIV0_EN.
module div_sched
    import div_pkg::*;
#(
    parameter  int D_W      = D_W_DEF,
    parameter  int FRAC_BIT = FRAC_BIT_DEF,
    parameter  int N_REQ    = N_REQ_DEF,
    localparam int IDW      = idw(N_REQ)
) (
    input  logic                   I_CLK,
    input  logic                   I_RST_N,
    input  logic [N_REQ-1:0]       I_REQ_VALID,
    output logic [N_REQ-1:0]       O_REQ_READY,
    input  logic [N_REQ*D_W-1:0]   I_DIVIDEND,
    input  logic [N_REQ*D_W-1:0]   I_DIVISOR,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic [D_W-1:0]         O_QUOTIENT,
`ifdef DIV_SCHED_DIV0_EN
    output logic                   O_DIV0,
`endif
    output logic [IDW-1:0]         O_ID
);

    typedef struct packed {
        logic                  valid;
        logic [IDW-1:0]        id;
        logic signed [D_W-1:0] dividend;
        logic signed [D_W-1:0] divisor;
    } s1_t;

    s1_t                   s1_q, s1_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [D_W-1:0]        s2_quot_q, s2_quot_d;
    logic [IDW-1:0]        s2_id_q, s2_id_d;

    logic                  s2_adv;
    logic                  accept_en;
    logic                  transfer;
    logic [N_REQ-1:0]      grant;
    logic [IDW-1:0]        sel_idx;
    logic signed [D_W-1:0] div_out;
    logic [D_W-1:0]        quot_fix;
    logic signed [D_W-1:0] dd_arr [N_REQ];
    logic signed [D_W-1:0] dv_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign dd_arr[g] = I_DIVIDEND[g*D_W +: D_W];
        assign dv_arr[g] = I_DIVISOR[g*D_W +: D_W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (I_CLK),
        .rst_n   (I_RST_N),
        .req     (I_REQ_VALID),
        .advance (transfer),
        .grant   (grant),
        .idx     (sel_idx)
    );

    div_fast #(.D_W(D_W), .FRAC_BIT(FRAC_BIT)) u_div (
        .dividend (s1_q.dividend),
        .divisor  (s1_q.divisor),
        .quotient (div_out)
    );

    // Ready is gated by reset so nothing is accepted while held in reset.
    always_comb begin
        s2_adv      = !s2_valid_q || I_READY;
        accept_en   = I_RST_N && (!s1_q.valid || s2_adv);
        O_REQ_READY = accept_en ? grant : '0;
        transfer    = |O_REQ_READY;
    end

`ifdef DIV_SCHED_DIV0_EN
    logic div0_q, div0_d, div0_now;

    always_comb begin
        div0_now = (s1_q.divisor == '0);
        quot_fix = div_out;
        if (div0_now) begin
            if (s1_q.dividend == '0) begin
                quot_fix = '0;
            end else if (s1_q.dividend[D_W-1]) begin
                quot_fix = {1'b1, {(D_W-1){1'b0}}};
            end else begin
                quot_fix = {1'b0, {(D_W-1){1'b1}}};
            end
        end
        div0_d = div0_q;
        if (s2_adv && s1_q.valid) begin
            div0_d = div0_now;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end

    assign O_DIV0 = div0_q;
`else
    always_comb begin
        quot_fix = div_out;
    end
`endif

    always_comb begin
        s1_d = s1_q;
        if (accept_en) begin
            s1_d.valid = transfer;
            if (transfer) begin
                s1_d.id       = sel_idx;
                s1_d.dividend = dd_arr[sel_idx];
                s1_d.divisor  = dv_arr[sel_idx];
            end
        end

        s2_valid_d = s2_valid_q;
        s2_quot_d  = s2_quot_q;
        s2_id_d    = s2_id_q;
        if (s2_adv) begin
            s2_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                s2_quot_d = quot_fix;
                s2_id_d   = s1_q.id;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_quot_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_quot_q  <= s2_quot_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign O_VALID    = s2_valid_q;
    assign O_QUOTIENT = s2_quot_q;
    assign O_ID       = s2_id_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched (Q2.13, four requesters).
module tb_div_sched;

    localparam int D_W = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             I_CLK = 1'b0;
    logic             I_RST_N;
    logic [N-1:0]     I_REQ_VALID;
    logic [N-1:0]     O_REQ_READY;
    logic [N*D_W-1:0] I_DIVIDEND;
    logic [N*D_W-1:0] I_DIVISOR;
    logic             O_VALID;
    logic             I_READY;
    logic [D_W-1:0]   O_QUOTIENT;
    logic [IDW-1:0]   O_ID;
`ifdef DIV_SCHED_DIV0_EN
    logic             O_DIV0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    div_sched dut (
        .I_CLK       (I_CLK),
        .I_RST_N     (I_RST_N),
        .I_REQ_VALID (I_REQ_VALID),
        .O_REQ_READY (O_REQ_READY),
        .I_DIVIDEND  (I_DIVIDEND),
        .I_DIVISOR   (I_DIVISOR),
        .O_VALID     (O_VALID),
        .I_READY     (I_READY),
        .O_QUOTIENT  (O_QUOTIENT),
`ifdef DIV_SCHED_DIV0_EN
        .O_DIV0      (O_DIV0),
`endif
        .O_ID        (O_ID)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] dd, input logic [15:0] dv);
        I_DIVIDEND[i*D_W +: D_W] = dd;
        I_DIVISOR[i*D_W +: D_W]  = dv;
    endtask

    initial begin
        I_RST_N     = 1'b0;
        I_REQ_VALID = '1;
        I_READY     = 1'b1;
        I_DIVIDEND  = '0;
        I_DIVISOR   = '0;
        for (int i = 0; i < N; i++) begin
            set_op(i, 16'h0800 * 16'(i + 1), 16'h2000);
        end

        // reset state, ready gated while reset is low
        #1;
        chk("rst_ready_low", 32'(O_REQ_READY), 32'h0);
        tick();
        tick();
        chk("rst_valid", 32'(O_VALID), 32'h0);
        chk("rst_quot", 32'(O_QUOTIENT), 32'h0);
        chk("rst_id", 32'(O_ID), 32'h0);
        chk("rst_ready", 32'(O_REQ_READY), 32'h0);

        // all four requesters, round robin from 0, one result per cycle
        I_RST_N = 1'b1;
        #1;
        chk("rr_first_ready", 32'(O_REQ_READY), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_ready", 32'(O_REQ_READY), 32'(4'b0001 << ((k + 1) % 4)));
            if (k >= 1) begin
                chk("rr_valid", 32'(O_VALID), 32'h1);
                chk("rr_id", 32'(O_ID), 32'((k - 1) % 4));
                chk("rr_quot", 32'(O_QUOTIENT), 32'(16'h0800 * 16'(((k - 1) % 4) + 1)));
            end else begin
                chk("rr_lat_valid", 32'(O_VALID), 32'h0);
            end
        end

        // downstream stall with full pipeline
        I_READY = 1'b0;
        #1;
        chk("stall_ready", 32'(O_REQ_READY), 32'h0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_valid", 32'(O_VALID), 32'h1);
            chk("stall_id", 32'(O_ID), 32'h2);
            chk("stall_quot", 32'(O_QUOTIENT), 32'h1800);
            chk("stall_ready_hold", 32'(O_REQ_READY), 32'h0);
        end
        I_READY = 1'b1;
        #1;
        chk("release_ready", 32'(O_REQ_READY), 32'h1);
        tick();
        I_REQ_VALID = '0;
        chk("release_id3", 32'(O_ID), 32'h3);
        chk("release_quot3", 32'(O_QUOTIENT), 32'h2000);
        tick();
        chk("release_valid0", 32'(O_VALID), 32'h1);
        chk("release_id0", 32'(O_ID), 32'h0);
        chk("release_quot0", 32'(O_QUOTIENT), 32'h0800);
        tick();
        chk("release_drain", 32'(O_VALID), 32'h0);

        // single requester 0: 1.0 / 2.0 = 0.5
        set_op(0, 16'h2000, 16'h4000);
        I_REQ_VALID = 4'b0001;
        #1;
        chk("r0_ready", 32'(O_REQ_READY), 32'h1);
        tick();
        I_REQ_VALID = '0;
        chk("r0_lat_valid", 32'(O_VALID), 32'h0);
        tick();
        chk("r0_valid", 32'(O_VALID), 32'h1);
        chk("r0_quot", 32'(O_QUOTIENT), 32'h1000);
        chk("r0_id", 32'(O_ID), 32'h0);
        tick();
        chk("r0_no_dup", 32'(O_VALID), 32'h0);

        // requester 2 back to back: signs, integer result, zero dividend
        set_op(2, 16'hE000, 16'h4000);
        I_REQ_VALID = 4'b0100;
        #1;
        chk("r2_ready_a", 32'(O_REQ_READY), 32'h4);
        tick();
        set_op(2, 16'h6000, 16'h2000);
        #1;
        chk("r2_ready_b", 32'(O_REQ_READY), 32'h4);
        tick();
        set_op(2, 16'h0000, 16'h4000);
        chk("r2_neg_quot", 32'(O_QUOTIENT), 32'hF000);
        chk("r2_neg_id", 32'(O_ID), 32'h2);
        tick();
        I_REQ_VALID = '0;
        chk("r2_int_quot", 32'(O_QUOTIENT), 32'h6000);
        tick();
        chk("r2_zero_valid", 32'(O_VALID), 32'h1);
        chk("r2_zero_quot", 32'(O_QUOTIENT), 32'h0);
        tick();
        chk("r2_drain", 32'(O_VALID), 32'h0);

`ifdef DIV_SCHED_DIV0_EN
        // divide by zero on requester 1
        set_op(1, 16'h2000, 16'h0000);
        I_REQ_VALID = 4'b0010;
        tick();
        set_op(1, 16'hE000, 16'h0000);
        tick();
        set_op(1, 16'h2000, 16'h4000);
        chk("d0_pos_quot", 32'(O_QUOTIENT), 32'h7FFF);
        chk("d0_pos_flag", 32'(O_DIV0), 32'h1);
        chk("d0_pos_id", 32'(O_ID), 32'h1);
        tick();
        I_REQ_VALID = '0;
        chk("d0_neg_quot", 32'(O_QUOTIENT), 32'h8000);
        chk("d0_neg_flag", 32'(O_DIV0), 32'h1);
        tick();
        chk("d0_clear_quot", 32'(O_QUOTIENT), 32'h1000);
        chk("d0_clear_flag", 32'(O_DIV0), 32'h0);
        tick();
`endif

        // reset with two operations in flight
        I_REQ_VALID = '1;
        tick();
        tick();
        chk("inflight_valid", 32'(O_VALID), 32'h1);
        I_RST_N = 1'b0;
        #1;
        chk("inrst_ready", 32'(O_REQ_READY), 32'h0);
        tick();
        chk("post_rst_valid", 32'(O_VALID), 32'h0);
        chk("post_rst_quot", 32'(O_QUOTIENT), 32'h0);
        I_REQ_VALID = '0;
        I_RST_N     = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("post_rst_quiet", 32'(O_VALID), 32'h0);
        end
        I_REQ_VALID = '1;
        #1;
        chk("post_rst_grant0", 32'(O_REQ_READY), 32'h1);
        tick();
        tick();
        chk("post_rst_res_valid", 32'(O_VALID), 32'h1);
        chk("post_rst_res_id", 32'(O_ID), 32'h0);
        I_REQ_VALID = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter D_W, default 16, signed fixed-point operand/result width.
REQ-002 SHALL have parameter FRAC_BIT, default 13, fraction bits (Q(D_W-1-FRAC_BIT).FRAC_BIT).
REQ-003 SHALL have parameter N_REQ, default 4, number of requesters (>=2); IDW = max(1, clog2(N_REQ)).
REQ-004 SHALL have port I_CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port I_RST_N, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port I_REQ_VALID, input, N_REQ, per-requester operand valid.
REQ-007 SHALL have port O_REQ_READY, output, N_REQ, per-requester accept; at most one bit high per cycle.
REQ-008 SHALL have port I_DIVIDEND, input, N_REQ*D_W; slice i = requester i dividend.
REQ-009 SHALL have port I_DIVISOR, input, N_REQ*D_W; slice i = requester i divisor.
REQ-010 SHALL have port O_VALID, output, 1, result valid.
REQ-011 SHALL have port I_READY, input, 1, downstream accepts result.
REQ-012 SHALL have port O_QUOTIENT, output, D_W, signed fixed-point quotient.
REQ-013 SHALL have port O_ID, output, IDW, index of requester owning O_QUOTIENT.

Function
REQ-014 SHALL share one combinational fixed-point divider among all requesters; transfer occurs on a cycle where I_REQ_VALID[i] and O_REQ_READY[i] are both high.
REQ-015 SHALL pipeline in two registered stages: S1 (operands + ID + valid) captured at accept; S2 (quotient + ID + valid) captured from divider output on S1.
REQ-016 SHALL present a result accepted at edge t on O_VALID after edge t+1 (2-cycle latency) when unstalled; sustained throughput one division per cycle.
REQ-017 SHALL advance S2 when !O_VALID or I_READY; S1 advances into S2 under the same condition; S1 accepts new operands when S1 empty or S1 advancing.
REQ-018 SHALL hold O_VALID, O_QUOTIENT, O_ID stable while O_VALID && !I_READY.
REQ-019 SHALL drive O_REQ_READY[i] = accept_enable && grant[i], grant combinational from I_REQ_VALID; no valid->ready dependency loop beyond that.
REQ-020 SHALL arbitrate round-robin: search starts at index (last_granted+1) mod N_REQ, wraps through N_REQ-1 to 0; pointer updates only on an actual transfer.
REQ-021 SHALL leave the pointer and grant unchanged while accept_enable is low (stalled requester keeps priority).
REQ-022 SHALL, with a single active requester, grant it every cycle accept_enable is high.
REQ-023 SHALL compute quotient = dividend / divisor, sign = XOR of operand signs, dividend 0 gives 0, result truncated to D_W bits (no saturation except per REQ-027).

Reset
REQ-024 SHALL on I_RST_N low at a clock edge clear S1/S2 valid, O_VALID=0, O_QUOTIENT=0, O_ID=0, round-robin pointer=N_REQ-1 (first search starts at 0).
REQ-025 SHALL hold O_REQ_READY all-zero while I_RST_N is low; in-flight operations are discarded, never emitted after reset.

Configuration
REQ-026 SHALL compile divide-by-zero handling only when macro DIV_SCHED_DIV0_EN is defined.
REQ-027 SHALL with DIV_SCHED_DIV0_EN: add port O_DIV0 (output, 1, valid with O_VALID, reset 0); divisor==0 gives O_DIV0=1 and quotient 0 for dividend 0, max positive (0x7FFF at D_W=16) for positive dividend, most negative (0x8000) for negative dividend.
REQ-028 SHALL without DIV_SCHED_DIV0_EN: no O_DIV0 port; divisor==0 passes unmodified divider output.

Structure
REQ-029 SHALL place D_W/FRAC_BIT defaults, IDW function and a stage record typedef (valid, id, dividend, divisor) in shared package div_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arbiter (req, advance -> one-hot grant, index); divider is the team's existing combinational div_fast instance.

Verification
REQ-031 SHALL cover: req0 only, 0x2000 / 0x4000 -> 2 cycles later O_VALID=1, O_QUOTIENT=0x1000, O_ID=0.
REQ-032 SHALL cover: all four valid continuously, I_READY=1 -> grants 0,1,2,3,0..., one result per cycle, IDs in grant order.
REQ-033 SHALL cover: I_READY low 5 cycles with pipeline full -> outputs held, O_REQ_READY 0, no result lost or duplicated after release.
REQ-034 SHALL cover: req2 0xE000 / 0x4000 -> 0xF000; 0x6000 / 0x2000 -> 0x6000; dividend 0 -> 0.
REQ-035 SHALL cover: DIV_SCHED_DIV0_EN, 0x2000 / 0 -> 0x7FFF, O_DIV0=1; 0xE000 / 0 -> 0x8000.
REQ-036 SHALL cover: I_RST_N low for one edge with two ops in flight -> O_VALID 0 next cycle, neither result ever appears, next grant to requester 0.
